// File: rtl/mem_req_pkg.sv
// Shared constants for the memory request controller: FSM encoding,
// memory mode pin values and default widths.
package mem_req_pkg;

  localparam int DEF_DW        = 32;
  localparam int DEF_AW        = 8;
  localparam int DEF_REQ_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  localparam logic MEM_MODE_READ  = 1'b1;
  localparam logic MEM_MODE_WRITE = 1'b0;

endpackage

// File: rtl/mem_req_fifo.sv
// Small request FIFO with a combinational head word so the FSM can pop
// and latch the next operation in the same cycle.
module mem_req_fifo #(
  parameter int W     = 41,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  logic [W-1:0]  store_reg [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW:0]   count_reg;
  logic          push_ok;
  logic          pop_ok;

  // A push while full is refused even if a pop happens in the same cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign full    = (count_reg == FULL_CNT);
  assign empty   = (count_reg == '0);
  assign dout    = store_reg[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      store_reg[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// Request-side controller for a single-port memory: buffers requests,
// issues them one at a time and returns one response per request, in order.
module mem_req_ctrl
  import mem_req_pkg::*;
#(
  parameter int DW        = DEF_DW,
  parameter int AW        = DEF_AW,
  parameter int REQ_DEPTH = DEF_REQ_DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_is_write,
  output logic [AW-1:0] rsp_addr,
  output logic [DW-1:0] rsp_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data_in,
  output logic          mem_mode,
  input  logic [DW-1:0] mem_data_out
);

  localparam int FW = DW + AW + 1;

  state_t        state_reg;
  logic          op_we_reg;
  logic [AW-1:0] op_addr_reg;
  logic [DW-1:0] op_wdata_reg;

  logic          rsp_valid_reg;
  logic          rsp_is_write_reg;
  logic [AW-1:0] rsp_addr_reg;
  logic [DW-1:0] rsp_rdata_reg;

  logic [FW-1:0] fifo_din;
  logic [FW-1:0] fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic          head_we;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_wdata;
  logic          issue_write;

  assign fifo_din = {req_we, req_addr, req_wdata};
  assign {head_we, head_addr, head_wdata} = fifo_dout;
  assign req_ready = !fifo_full;

  mem_req_fifo #(
    .W     (FW),
    .DEPTH (REQ_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_valid),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Pop from IDLE, or straight out of RESP when the response is consumed.
  always_comb begin
    fifo_pop = 1'b0;
    if (!fifo_empty) begin
      if (state_reg == ST_IDLE) begin
        fifo_pop = 1'b1;
      end else if (state_reg == ST_RESP && rsp_ready) begin
        fifo_pop = 1'b1;
      end
    end
  end

  // Memory pins decode from state registers only, so the write strobe
  // drops the instant reset asserts and an in-flight write is abandoned.
  assign issue_write = (state_reg == ST_ISSUE) && op_we_reg;
  assign mem_mode    = issue_write ? MEM_MODE_WRITE : MEM_MODE_READ;
  assign mem_data_in = issue_write ? op_wdata_reg : '0;
  assign mem_addr    = op_addr_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      op_we_reg        <= 1'b0;
      op_addr_reg      <= '0;
      op_wdata_reg     <= '0;
      rsp_valid_reg    <= 1'b0;
      rsp_is_write_reg <= 1'b0;
      rsp_addr_reg     <= '0;
      rsp_rdata_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (!fifo_empty) begin
            op_we_reg    <= head_we;
            op_addr_reg  <= head_addr;
            op_wdata_reg <= head_wdata;
            state_reg    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          rsp_valid_reg    <= 1'b1;
          rsp_is_write_reg <= op_we_reg;
          rsp_addr_reg     <= op_addr_reg;
          rsp_rdata_reg    <= op_we_reg ? '0 : mem_data_out;
          state_reg        <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            if (!fifo_empty) begin
              op_we_reg    <= head_we;
              op_addr_reg  <= head_addr;
              op_wdata_reg <= head_wdata;
              state_reg    <= ST_ISSUE;
            end else begin
              state_reg <= ST_IDLE;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid    = rsp_valid_reg;
  assign rsp_is_write = rsp_is_write_reg;
  assign rsp_addr     = rsp_addr_reg;
  assign rsp_rdata    = rsp_rdata_reg;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Scoreboard bench for mem_req_ctrl with a behavioural 256x32 memory attached.
module tb_mem_req_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_is_write;
  logic [7:0]  rsp_addr;
  logic [31:0] rsp_rdata;
  logic [7:0]  mem_addr;
  logic [31:0] mem_data_in;
  logic        mem_mode;
  logic [31:0] mem_data_out;

  always #5 clk = ~clk;

  mem_req_ctrl #(.DW(32), .AW(8), .REQ_DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_is_write (rsp_is_write),
    .rsp_addr     (rsp_addr),
    .rsp_rdata    (rsp_rdata),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_mode     (mem_mode),
    .mem_data_out (mem_data_out)
  );

  // Single-port memory: write on posedge while mode=0, combinational read while mode=1.
  bit [31:0] mem_model [256];
  always @(posedge clk) begin
    if (mem_mode == 1'b0) mem_model[mem_addr] <= mem_data_in;
  end
  assign mem_data_out = mem_mode ? mem_model[mem_addr] : 32'h0;

  typedef struct packed {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t      exp_q[$];
  bit [31:0] ref_mem [256];
  int        vectors = 0;
  int        errors  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Acceptance side: a handshake seen at negedge completes on the next posedge.
  exp_t acc_e;
  always @(negedge clk) begin
    if (rst_n && req_valid && req_ready) begin
      acc_e.we   = req_we;
      acc_e.addr = req_addr;
      if (req_we) begin
        acc_e.data        = 32'h0;
        ref_mem[req_addr] = req_wdata;
      end else begin
        acc_e.data = ref_mem[req_addr];
      end
      exp_q.push_back(acc_e);
    end
  end

  // Response side: compare on handshake, check stability while stalled.
  exp_t        rsp_e;
  bit          stall_prev = 1'b0;
  logic [41:0] held;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        check("rsp_stable", {22'h0, rsp_valid, rsp_is_write, rsp_addr, rsp_rdata}, {22'h0, held});
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL rsp_unexpected: got addr %0h data %0h, expected no response", rsp_addr, rsp_rdata);
        end else begin
          rsp_e = exp_q.pop_front();
          check("rsp_is_write", {63'h0, rsp_is_write}, {63'h0, rsp_e.we});
          check("rsp_addr", {56'h0, rsp_addr}, {56'h0, rsp_e.addr});
          check("rsp_rdata", {32'h0, rsp_rdata}, {32'h0, rsp_e.data});
          $display("rsp we=%0d addr=%02h rdata=%08h", rsp_is_write, rsp_addr, rsp_rdata);
        end
      end
      stall_prev = rsp_valid && !rsp_ready;
      held       = {rsp_valid, rsp_is_write, rsp_addr, rsp_rdata};
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic we, input logic [7:0] a, input logic [31:0] d);
    bit ok;
    ok        = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = req_ready;
    end
    if (!ok) begin
      vectors++;
      errors++;
      $display("FAIL send_timeout: req_ready stayed 0, expected 1 within 100 cycles");
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && !rsp_valid;
    end
    check("drain_pending", 64'(exp_q.size()), 64'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 8'h0;
    req_wdata = 32'h0;
    rsp_ready = 1'b0;

    // 1: reset with random inputs
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'($urandom);
      req_we    = 1'($urandom);
      req_addr  = 8'($urandom);
      req_wdata = $urandom;
      rsp_ready = 1'($urandom);
      @(negedge clk);
      check("rst_rsp_valid", {63'h0, rsp_valid}, 64'h0);
      check("rst_mem_mode", {63'h0, mem_mode}, 64'h1);
      check("rst_req_ready", {63'h0, req_ready}, 64'h1);
      check("rst_outputs", {rsp_is_write, rsp_addr, rsp_rdata, mem_addr},
            64'h0);
      check("rst_mem_data_in", {32'h0, mem_data_in}, 64'h0);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    rst_n     = 1'b1;
    @(posedge clk);
    #1;

    // 2: write then read @0x10, with latency check
    rsp_ready = 1'b1;
    send(1'b1, 8'h10, 32'hDEADBEEF);
    @(negedge clk);
    check("lat_edge_n", {63'h0, rsp_valid}, 64'h0);
    @(negedge clk);
    check("lat_edge_n1", {63'h0, rsp_valid}, 64'h0);
    @(negedge clk);
    check("lat_edge_n2", {63'h0, rsp_valid}, 64'h1);
    @(posedge clk);
    #1;
    send(1'b0, 8'h10, 32'h0);
    drain();

    // 3: stalled consumer, FIFO fills, then in-order release
    for (int i = 0; i < 5; i++) send(1'b1, 8'h30 + 8'(i), 32'hA000_0000 + 32'(i * 17));
    drain();
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(1'b0, 8'h30 + 8'(i), 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("full_req_ready", {63'h0, req_ready}, 64'h0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    drain();

    // 4: top address, no aliasing onto 0x00
    send(1'b1, 8'h00, 32'h12345678);
    send(1'b1, 8'hFF, 32'hFFFFFFFF);
    send(1'b0, 8'hFF, 32'h0);
    send(1'b0, 8'h00, 32'h0);
    drain();

    // 5: reset during an issuing write leaves memory unchanged
    send(1'b1, 8'h20, 32'h55);
    drain();
    send(1'b1, 8'h20, 32'h1);
    @(posedge clk);
    #1;
    check("issue_write_mode", {63'h0, mem_mode}, 64'h0);
    rst_n = 1'b0;
    #1;
    check("async_rst_mode", {63'h0, mem_mode}, 64'h1);
    check("async_rst_data_in", {32'h0, mem_data_in}, 64'h0);
    check("async_rst_addr", {56'h0, mem_addr}, 64'h0);
    exp_q.delete();
    ref_mem[8'h20] = 32'h55;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_idle", {62'h0, rsp_valid, req_ready}, 64'h1);
    end
    @(posedge clk);
    #1;
    send(1'b0, 8'h20, 32'h0);
    drain();

    // 6: full FIFO, pop and push requested in the same cycle
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(1'b0, 8'h30 + 8'(i), 32'h0);
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 8'h34;
    req_wdata = 32'h0;
    @(negedge clk);
    check("full_pop_push_refused", {63'h0, req_ready}, 64'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("push_next_cycle", {63'h0, req_ready}, 64'h1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
